shift_divider_signed: RTL and testbench
=======================================

Name: shift_divider_signed

Overview:
- Parametrised sequential shift/subtract divider with an integrated control FSM; the next generation of the 8-bit `divider`.
- Adds:
  - W-bit width.
  - Optional two's-complement signed mode.
  - Quotient and remainder outputs.
  - A busy flag.
  - Overflow detection.
- Sits behind the system bus as a multi-cycle arithmetic unit, started by a one-cycle request and answered by a one-cycle done pulse.

Parameters:
- W, 8, operand/result width in bits (W >= 4).
- SIGNED_EN, 1, 1 = honour the signed_mode input; 0 = signed_mode ignored, unsigned-only logic.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = operands are two's complement; captured with start.
- dividend  in  W  captured on the start-sampling edge.
- divisor  in  W  captured on the start-sampling edge.
- quotient  out  W  result; held until the next completion.
- remainder  out  W  result; held until the next completion.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion; also pulses on error.
- error  out  1  one-cycle pulse, divide by zero.
- overflow  out  1  one-cycle pulse with done, signed quotient not representable.

Behaviour:
- Reset (async, any state): state=IDLE; quotient, remainder, busy, done, error, overflow all 0; internal registers cleared.
- States: IDLE, CHECK, NORMALIZE, DIVIDE, FIXSIGN, DONE, ERROR.
- IDLE:
  - start=1 captures operands and sgn = signed_mode & SIGNED_EN.
  - Forms magnitudes a=|dividend|, b=|divisor| when sgn, else raw values.
  - Sets rem=a, d=b, q=0, cnt=0; then -> CHECK.
  - start=0 stays in IDLE.
- CHECK: b==0 -> ERROR; else -> NORMALIZE.
- NORMALIZE, per cycle:
  - If d[W-1]==0 and (d<<1) <= rem: d<=d<<1, cnt<=cnt+1, stay.
  - Else -> DIVIDE.
  - Comparison is unsigned, W+1 bits wide, so no wrap occurs.
- DIVIDE, per cycle:
  - q <= {q[W-2:0], rem>=d}.
  - If rem>=d: rem <= rem-d.
  - d <= d>>1.
  - cnt==0 -> FIXSIGN; else cnt <= cnt-1.
  - Runs exactly k+1 cycles, where k = number of NORMALIZE shifts.
- FIXSIGN:
  - Quotient: negated if sgn and the operand signs differ.
  - Remainder: negated if sgn and the dividend is negative; truncation toward zero, remainder takes the dividend's sign.
  - overflow_pending = sgn & (dividend == 1 followed by W-1 zeros, i.e. the most negative value) & (divisor == all ones, i.e. -1).
  - Load quotient and remainder outputs; -> DONE.
- DONE: done=1 and overflow=overflow_pending for one cycle; -> IDLE unconditionally.
- ERROR:
  - done=1 and error=1 for one cycle.
  - quotient = all ones; remainder = captured dividend.
  - -> IDLE.
- Latency, counting the start-sampling edge as edge 1:
  - DONE is entered on edge 2k+5.
  - ERROR is entered on edge 2.
  - Worst case is k=W-1, i.e. edge 2W+3.
- Overflow case (-2^(W-1) / -1): quotient = 2^(W-1) bit pattern (the most negative value, wraps); remainder = 0; done=1, overflow=1, error=0.
- start while busy: ignored, no queuing.
- start held high: a new operation begins on the first IDLE cycle after DONE/ERROR.
- Dividend 0 (divisor != 0): q=0, r=0 via the normal path; k=0.
- Divisor > dividend: k=0; q=0; r=dividend.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset with busy=1 mid-DIVIDE, released after 2 cycles -> all outputs 0, state IDLE; next start=1 is accepted.
- W=8, unsigned, 100/7 -> quotient=14 (0x0E), remainder=2; done pulses exactly once, entered on edge 11 (k=3); busy high edges 1..10.
- W=8, signed_mode=1:
  - -100/7 -> quotient=0xF2 (-14), remainder=0xFE (-2).
  - 100/-7 -> quotient=0xF2, remainder=0x02.
  - -100/-7 -> quotient=0x0E, remainder=0xFE.
- Divide by zero: 55/0 -> ERROR on edge 2; done=1, error=1 for one cycle; quotient=0xFF, remainder=0x37; next op 255/1 unsigned -> quotient=0xFF, remainder=0, done on edge 19 (k=7).
- Signed overflow: -128/-1 -> quotient=0x80, remainder=0, done=1, overflow=1, error=0; then 0/5 -> quotient=0, remainder=0, overflow=0.
- start pulsed during DIVIDE of 200/3 -> ignored; result quotient=66, remainder=2; exactly one done pulse.

Source files
------------

// File: rtl/shift_divider_signed.sv
// shift_divider_signed
//   Multi-cycle shift/subtract divider with an integrated control FSM.
//   A one-cycle start request captures the operands. The unit then
//   normalises the divisor against the dividend magnitude and runs a
//   restoring shift/subtract loop. Signs are fixed up afterwards, and
//   the result is reported with a one-cycle done pulse. Signed division
//   truncates toward zero, and the remainder takes the dividend's sign.
//
// Parameters
//   W          operand/result width in bits (W >= 4)
//   SIGNED_EN  1 = honour signed_mode, 0 = unsigned-only operation
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   start        request, sampled only while idle
//   signed_mode  operands are two's complement (captured with start)
//   dividend     W-bit dividend (captured with start)
//   divisor      W-bit divisor  (captured with start)
//   quotient     W-bit result, held until the next completion
//   remainder    W-bit result, held until the next completion
//   busy         high whenever the unit is not idle
//   done         one-cycle completion pulse (also on divide by zero)
//   error        one-cycle pulse alongside done for divide by zero
//   overflow     one-cycle pulse alongside done for -2^(W-1) / -1
module shift_divider_signed #(
  parameter int W         = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         signed_mode,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         overflow
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam logic [W-1:0]  ONE     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_NORMALIZE,
    S_DIVIDE,
    S_FIXSIGN,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state, next_state;

  logic signed [W-1:0] dvd_cap;
  logic signed [W-1:0] dvs_cap;
  logic                sgn;
  logic [W-1:0]        rem;
  logic [W-1:0]        d;
  logic [W-1:0]        q;
  logic [CW-1:0]       cnt;

  // Two's-complement negate and magnitude helpers.
  function automatic logic [W-1:0] neg(input logic [W-1:0] x);
    return ~x + ONE;
  endfunction

  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic en);
    return (en && x[W-1]) ? neg(x) : x;
  endfunction

  logic start_sgn;
  logic norm_ok;
  logic rem_ge;
  logic neg_q;
  logic neg_r;
  logic ovf_cond;

  assign start_sgn = signed_mode & SIGNED_EN;
  // Compare at W+1 bits so the shifted divisor cannot wrap.
  assign norm_ok   = ~d[W-1] && ({d, 1'b0} <= {1'b0, rem});
  assign rem_ge    = (rem >= d);
  assign neg_q     = sgn & (dvd_cap[W-1] ^ dvs_cap[W-1]);
  assign neg_r     = sgn & dvd_cap[W-1];
  assign ovf_cond  = sgn && (dvd_cap == MOST_NEG) && (dvs_cap == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:      if (start) next_state = S_CHECK;
      S_CHECK:     next_state = (d == '0) ? S_ERROR : S_NORMALIZE;
      S_NORMALIZE: if (!norm_ok) next_state = S_DIVIDE;
      S_DIVIDE:    if (cnt == '0) next_state = S_FIXSIGN;
      S_FIXSIGN:   next_state = S_DONE;
      S_DONE:      next_state = S_IDLE;
      S_ERROR:     next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_cap   <= '0;
      dvs_cap   <= '0;
      sgn       <= 1'b0;
      rem       <= '0;
      d         <= '0;
      q         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      // Status flags are registered from the next state so they line up
      // with the state they describe.
      busy     <= (next_state != S_IDLE);
      done     <= (next_state == S_DONE) || (next_state == S_ERROR);
      error    <= (next_state == S_ERROR);
      overflow <= (state == S_FIXSIGN) && ovf_cond;

      unique case (state)
        S_IDLE: begin
          if (start) begin
            dvd_cap <= dividend;
            dvs_cap <= divisor;
            sgn     <= start_sgn;
            rem     <= mag(dividend, start_sgn);
            d       <= mag(divisor, start_sgn);
            q       <= '0;
            cnt     <= '0;
          end
        end
        S_CHECK: begin
          if (d == '0) begin
            quotient  <= '1;
            remainder <= dvd_cap;
          end
        end
        S_NORMALIZE: begin
          if (norm_ok) begin
            d   <= {d[W-2:0], 1'b0};
            cnt <= cnt + CNT_ONE;
          end
        end
        S_DIVIDE: begin
          q <= {q[W-2:0], rem_ge};
          if (rem_ge) rem <= rem - d;
          d <= {1'b0, d[W-1:1]};
          if (cnt != '0) cnt <= cnt - CNT_ONE;
        end
        S_FIXSIGN: begin
          // A most-negative quotient wraps back onto itself, which gives
          // the required bit pattern for the overflow case.
          quotient  <= neg_q ? neg(q) : q;
          remainder <= neg_r ? neg(rem) : rem;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_divider_signed.sv
module tb_shift_divider_signed;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         signed_mode;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         error;
  logic         overflow;

  shift_divider_signed #(.W(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .dividend(dividend), .divisor(divisor), .quotient(quotient),
    .remainder(remainder), .busy(busy), .done(done), .error(error),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic         sm;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         e;
    logic         o;
    int           lat;
  } vec_t;

  // Reference: plain integer division (truncating toward zero). Latency is
  // derived from k = largest shift with (|b| << k) <= |a|.
  function automatic void model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic e, output logic o, output int lat);
    longint sa, sb, ua, ub, qi, ri;
    int k;
    e = 1'b0; o = 1'b0;
    if (b == '0) begin
      q = '1; r = a; e = 1'b1; lat = 2;
      return;
    end
    if (sm) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      qi = sa / sb;
      ri = sa % sb;
      o  = (sa == -(longint'(1) << (W-1))) && (sb == -1);
      ua = (sa < 0) ? -sa : sa;
      ub = (sb < 0) ? -sb : sb;
    end else begin
      ua = longint'(a);
      ub = longint'(b);
      qi = ua / ub;
      ri = ua % ub;
    end
    q = qi[W-1:0];
    r = ri[W-1:0];
    k = 0;
    while ((ub << (k + 1)) <= ua) k++;
    lat = 2 * k + 5;
  endfunction

  // Runs one operation. lat is the edge (start-sampling edge = 1) after
  // which done was seen, or -1 on timeout.
  task automatic do_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic e, output logic o, output int lat,
                       output logic busy_ok, output logic pulse_ok);
    @(negedge clk);
    start = 1'b1; signed_mode = sm; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
    signed_mode = 1'($urandom);
    busy_ok = 1'b1;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) lat = -1;
    if (busy !== 1'b1) busy_ok = 1'b0;
    q = quotient; r = remainder; e = error; o = overflow;
    @(negedge clk);
    pulse_ok = (done === 1'b0) && (busy === 1'b0) && (error === 1'b0) && (overflow === 1'b0);
  endtask

  task automatic run_and_check(input string name, input vec_t v);
    logic [W-1:0] q, r;
    logic e, o, bok, pok;
    int lat;
    do_op(v.sm, v.a, v.b, q, r, e, o, lat, bok, pok);
    check({name, ".lat"}, lat, v.lat);
    check({name, ".q"}, q, v.q);
    check({name, ".r"}, r, v.r);
    check({name, ".err"}, e, v.e);
    check({name, ".ovf"}, o, v.o);
    check({name, ".busy"}, bok, 1);
    check({name, ".pulse"}, pok, 1);
  endtask

  vec_t tbl[11];

  initial begin
    logic [W-1:0] q, r;
    logic e, o;
    int lat, ndone, first_at, second_at;
    vec_t v;

    tbl[0]  = '{1'b0, 8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0, 11};
    tbl[1]  = '{1'b1, 8'h9C,  8'd7,   8'hF2, 8'hFE, 1'b0, 1'b0, 11};
    tbl[2]  = '{1'b1, 8'd100, 8'hF9,  8'hF2, 8'h02, 1'b0, 1'b0, 11};
    tbl[3]  = '{1'b1, 8'h9C,  8'hF9,  8'h0E, 8'hFE, 1'b0, 1'b0, 11};
    tbl[4]  = '{1'b0, 8'd55,  8'd0,   8'hFF, 8'h37, 1'b1, 1'b0, 2};
    tbl[5]  = '{1'b0, 8'd255, 8'd1,   8'hFF, 8'h00, 1'b0, 1'b0, 19};
    tbl[6]  = '{1'b1, 8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1, 19};
    tbl[7]  = '{1'b1, 8'd0,   8'd5,   8'h00, 8'h00, 1'b0, 1'b0, 5};
    tbl[8]  = '{1'b0, 8'd3,   8'd200, 8'h00, 8'h03, 1'b0, 1'b0, 5};
    tbl[9]  = '{1'b0, 8'd200, 8'd3,   8'd66, 8'd2,  1'b0, 1'b0, 17};
    tbl[10] = '{1'b0, 8'h9C,  8'd7,   8'd22, 8'd2,  1'b0, 1'b0, 13};

    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst.q", quotient, 0);
    check("rst.r", remainder, 0);
    check("rst.flags", {busy, done, error, overflow}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst.idle_busy", busy, 0);

    for (int i = 0; i < 11; i++) run_and_check($sformatf("vec%0d", i), tbl[i]);

    // Reset while mid-DIVIDE (255/1: DIVIDE spans edges 11..18).
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; dividend = 8'd255; divisor = 8'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("midrst.busy_before", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("midrst.async_q", quotient, 0);
    check("midrst.async_flags", {busy, done, error, overflow}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst.held_q", {quotient, remainder}, 0);
    @(negedge clk);
    check("midrst.after_flags", {busy, done, error, overflow}, 0);
    run_and_check("midrst.next", tbl[0]);

    // start pulsed during DIVIDE of 200/3 (k=6, DIVIDE on edges 10..16).
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; dividend = 8'd200; divisor = 8'd3;
    ndone = 0; q = '0; r = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (i == 11) begin start = 1'b1; dividend = 8'd9; divisor = 8'd9; end
      if (i == 12) start = 1'b0;
      if (done === 1'b1) begin ndone++; q = quotient; r = remainder; end
    end
    check("busystart.ndone", ndone, 1);
    check("busystart.q", q, 66);
    check("busystart.r", r, 2);

    // start held high: second op begins on the IDLE cycle after DONE.
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; dividend = 8'd100; divisor = 8'd7;
    ndone = 0; first_at = -1; second_at = -1;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if (i == 24) start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (first_at < 0) first_at = i;
        else if (second_at < 0) second_at = i;
      end
    end
    check("held.ndone", ndone, 2);
    check("held.first", first_at, 11);
    check("held.second", second_at, 23);
    check("held.idle", busy, 0);

    // Randomised operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      v.sm = 1'($urandom);
      v.a  = W'($urandom);
      case ($urandom_range(0, 7))
        0:       v.b = '0;
        1, 2:    v.b = W'($urandom_range(1, 7));
        3:       v.b = '1;
        default: v.b = W'($urandom);
      endcase
      if (i % 37 == 0) begin v.sm = 1'b1; v.a = 8'h80; v.b = 8'hFF; end
      model(v.sm, v.a, v.b, v.q, v.r, v.e, v.o, v.lat);
      run_and_check($sformatf("rnd%0d", i), v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
